// File: rtl/cp0_pkg.sv
// ============================================================================
// Module   : cp0_pkg
// Purpose  : Shared CP0 register numbers, ExcCode values and field positions.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cp0_pkg;

   localparam logic [4:0] C_REG_SR    = 5'd12;
   localparam logic [4:0] C_REG_CAUSE = 5'd13;
   localparam logic [4:0] C_REG_EPC   = 5'd14;
   localparam logic [4:0] C_REG_PRID  = 5'd15;

   localparam logic [4:0] C_EXC_INT  = 5'd0;
   localparam logic [4:0] C_EXC_ADEL = 5'd4;
   localparam logic [4:0] C_EXC_ADES = 5'd5;
   localparam logic [4:0] C_EXC_RI   = 5'd10;
   localparam logic [4:0] C_EXC_OV   = 5'd12;

   localparam int C_SR_IE_BIT     = 0;
   localparam int C_SR_EXL_BIT    = 1;
   localparam int C_IM_LO         = 10;
   localparam int C_IM_HI         = 15;
   localparam int C_CAUSE_BD_BIT  = 31;
   localparam int C_EXCCODE_LO    = 2;
   localparam int C_EXCCODE_HI    = 6;

endpackage

`default_nettype wire

// File: rtl/cp0_exc_arb.sv
// ============================================================================
// Module   : cp0_exc_arb
// Purpose  : Combinational interrupt/exception detect and ExcCode select.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cp0_exc_arb
   import cp0_pkg::*;
(
   input  logic       pc_valid_i,
   input  logic       exc_valid_i,
   input  logic [4:0] exccode_i,
   input  logic       ie_i,
   input  logic       exl_i,
   input  logic [5:0] im_i,
   input  logic [5:0] hwint_i,
   output logic       flush_o,
   output logic [4:0] exccode_o
);

   logic w_irq;
   logic w_exc;

   assign w_irq     = pc_valid_i & ie_i & ~exl_i & (|(hwint_i & im_i));
   assign w_exc     = pc_valid_i & exc_valid_i & ~exl_i;
   assign flush_o   = w_irq | w_exc;
   // Interrupts outrank the synchronous exception of the same instruction.
   assign exccode_o = w_irq ? C_EXC_INT : exccode_i;

endmodule

`default_nettype wire

// File: rtl/cp0_ctrl.sv
// ============================================================================
// Module   : cp0_ctrl
// Purpose  : CP0 SR/Cause/EPC/PRId registers, mfc0/mtc0/eret, flush source.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cp0_ctrl
   import cp0_pkg::*;
#(
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
   parameter logic [31:0] PRID_VAL     = 32'h0000_0715
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pcM,
   input  logic        pc_validM,
   input  logic        bdM,
   input  logic        exc_validM,
   input  logic [4:0]  exccodeM,
   input  logic        eretM,
   input  logic [5:0]  hwint,
   input  logic        cp0_we,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   output logic [31:0] cp0_rdata,
   output logic        flush,
   output logic [31:0] handler_pc,
   output logic [31:0] epc_out
);

   logic [5:0]  r_im_q,   r_im_d;
   logic        r_exl_q,  r_exl_d;
   logic        r_ie_q,   r_ie_d;
   logic        r_bd_q,   r_bd_d;
   logic [5:0]  r_ip_q,   r_ip_d;
   logic [4:0]  r_code_q, r_code_d;
   logic [31:0] r_epc_q,  r_epc_d;

   logic        w_flush;
   logic [4:0]  w_code;
   logic [31:0] w_epc_exc;
   logic [31:0] w_sr;
   logic [31:0] w_cause;

   cp0_exc_arb u_arb (
      .pc_valid_i  (pc_validM),
      .exc_valid_i (exc_validM),
      .exccode_i   (exccodeM),
      .ie_i        (r_ie_q),
      .exl_i       (r_exl_q),
      .im_i        (r_im_q),
      .hwint_i     (hwint),
      .flush_o     (w_flush),
      .exccode_o   (w_code)
   );

   // A delay-slot fault restarts at the branch so the branch is re-executed.
   assign w_epc_exc = (bdM ? (pcM - 32'd4) : pcM) & 32'hFFFF_FFFC;

   always_comb begin
      r_im_d   = r_im_q;
      r_exl_d  = r_exl_q;
      r_ie_d   = r_ie_q;
      r_bd_d   = r_bd_q;
      r_ip_d   = hwint;
      r_code_d = r_code_q;
      r_epc_d  = r_epc_q;
      if (w_flush) begin
         r_exl_d  = 1'b1;
         r_bd_d   = bdM;
         r_code_d = w_code;
         r_epc_d  = w_epc_exc;
      end else begin
         if (eretM && pc_validM) begin
            r_exl_d = 1'b0;
         end
         if (cp0_we) begin
            case (cp0_addr)
               C_REG_SR: begin
                  r_im_d  = cp0_wdata[C_IM_HI:C_IM_LO];
                  r_exl_d = cp0_wdata[C_SR_EXL_BIT];
                  r_ie_d  = cp0_wdata[C_SR_IE_BIT];
               end
               C_REG_EPC: r_epc_d = {cp0_wdata[31:2], 2'b00};
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_im_q   <= '0;
         r_exl_q  <= 1'b0;
         r_ie_q   <= 1'b0;
         r_bd_q   <= 1'b0;
         r_ip_q   <= '0;
         r_code_q <= '0;
         r_epc_q  <= '0;
      end else begin
         r_im_q   <= r_im_d;
         r_exl_q  <= r_exl_d;
         r_ie_q   <= r_ie_d;
         r_bd_q   <= r_bd_d;
         r_ip_q   <= r_ip_d;
         r_code_q <= r_code_d;
         r_epc_q  <= r_epc_d;
      end
   end

   assign w_sr    = {16'h0, r_im_q, 8'h0, r_exl_q, r_ie_q};
   assign w_cause = {r_bd_q, 15'h0, r_ip_q, 3'h0, r_code_q, 2'b00};

   always_comb begin
      cp0_rdata = 32'h0;
      case (cp0_addr)
         C_REG_SR:    cp0_rdata = w_sr;
         C_REG_CAUSE: cp0_rdata = w_cause;
         C_REG_EPC:   cp0_rdata = r_epc_q;
         C_REG_PRID:  cp0_rdata = PRID_VAL;
         default:     cp0_rdata = 32'h0;
      endcase
   end

   assign flush      = w_flush;
   assign handler_pc = HANDLER_ADDR;
   assign epc_out    = r_epc_q;

endmodule

`default_nettype wire

// File: tb/tb_cp0_ctrl.sv
// ============================================================================
// Module   : tb_cp0_ctrl
// Purpose  : Directed self-checking bench for cp0_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cp0_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pcM;
   logic        pc_validM;
   logic        bdM;
   logic        exc_validM;
   logic [4:0]  exccodeM;
   logic        eretM;
   logic [5:0]  hwint;
   logic        cp0_we;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic [31:0] cp0_rdata;
   logic        flush;
   logic [31:0] handler_pc;
   logic [31:0] epc_out;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cp0_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .pcM        (pcM),
      .pc_validM  (pc_validM),
      .bdM        (bdM),
      .exc_validM (exc_validM),
      .exccodeM   (exccodeM),
      .eretM      (eretM),
      .hwint      (hwint),
      .cp0_we     (cp0_we),
      .cp0_addr   (cp0_addr),
      .cp0_wdata  (cp0_wdata),
      .cp0_rdata  (cp0_rdata),
      .flush      (flush),
      .handler_pc (handler_pc),
      .epc_out    (epc_out)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
      cp0_addr = a;
      #1;
      chk(tag, cp0_rdata, exp);
   endtask

   task automatic chk_flush(input string tag, input logic exp);
      #1;
      chk(tag, {31'h0, flush}, {31'h0, exp});
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      cp0_we = 1'b1; cp0_addr = a; cp0_wdata = d;
      step();
      cp0_we = 1'b0;
   endtask

   initial begin
      rst = 1'b1; pcM = '0; pc_validM = 1'b0; bdM = 1'b0; exc_validM = 1'b0;
      exccodeM = '0; eretM = 1'b0; hwint = '0; cp0_we = 1'b0; cp0_addr = '0;
      cp0_wdata = '0;
      step(); step();
      rst = 1'b0;

      rd("rst_sr", 5'd12, 32'h0);
      rd("rst_cause", 5'd13, 32'h0);
      rd("rst_epc", 5'd14, 32'h0);
      rd("prid", 5'd15, 32'h0000_0715);
      chk("handler_pc", handler_pc, 32'h0000_4180);
      chk_flush("rst_flush", 1'b0);

      // IE=1, IM=0, hwint[2] pending: IP visible, no interrupt taken
      hwint = 6'b000100;
      mtc0(5'd12, 32'h0000_0001);
      pcM = 32'h3000; pc_validM = 1'b1;
      chk_flush("im0_flush", 1'b0);
      rd("ip_cause", 5'd13, 32'h0000_1000);
      rd("sr_ie", 5'd12, 32'h0000_0001);

      // interrupt outside delay slot
      mtc0(5'd12, 32'h0000_0401);
      hwint = 6'b000001; pcM = 32'h3008; bdM = 1'b0;
      chk_flush("irq_flush", 1'b1);
      step();
      rd("irq_epc", 5'd14, 32'h0000_3008);
      chk("irq_epc_out", epc_out, 32'h0000_3008);
      rd("irq_cause", 5'd13, 32'h0000_0400);
      rd("irq_sr", 5'd12, 32'h0000_0403);
      chk_flush("exl_blocks_irq", 1'b0);

      // eret back to EXL=0
      hwint = '0; eretM = 1'b1;
      step();
      eretM = 1'b0;
      rd("eret1_sr", 5'd12, 32'h0000_0401);

      // overflow in a delay slot
      exc_validM = 1'b1; exccodeM = 5'd12; pcM = 32'h3010; bdM = 1'b1;
      chk_flush("ov_flush", 1'b1);
      step();
      exc_validM = 1'b0; bdM = 1'b0;
      rd("ov_epc", 5'd14, 32'h0000_300C);
      rd("ov_cause", 5'd13, 32'h8000_0030);

      // EXL=1: further exception ignored
      exc_validM = 1'b1; exccodeM = 5'd4;
      chk_flush("exl_blocks_exc", 1'b0);
      step();
      exc_validM = 1'b0;
      rd("exl_cause_kept", 5'd13, 32'h8000_0030);

      // eret: EXL clears, EPC unchanged; EPC write aligns and is not forwarded
      eretM = 1'b1;
      step();
      eretM = 1'b0;
      rd("eret2_sr", 5'd12, 32'h0000_0401);
      chk("eret2_epc_out", epc_out, 32'h0000_300C);
      cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_3003;
      #1;
      chk("no_forward", cp0_rdata, 32'h0000_300C);
      step();
      cp0_we = 1'b0;
      rd("epc_align", 5'd14, 32'h0000_3000);

      // irq + exception + mtc0 EPC in the same cycle
      hwint = 6'b000001; exc_validM = 1'b1; exccodeM = 5'd10; pcM = 32'h3014;
      cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_FFFF;
      chk_flush("simul_flush", 1'b1);
      step();
      cp0_we = 1'b0; exc_validM = 1'b0; hwint = '0;
      rd("simul_epc", 5'd14, 32'h0000_3014);
      rd("simul_cause", 5'd13, 32'h0000_0400);
      eretM = 1'b1;
      step();
      eretM = 1'b0;

      // bubble holds off a pending interrupt
      hwint = 6'b000001; pc_validM = 1'b0; pcM = 32'h0;
      chk_flush("bubble_flush", 1'b0);
      step();
      rd("bubble_sr", 5'd12, 32'h0000_0401);
      pc_validM = 1'b1; pcM = 32'h3020;
      chk_flush("after_bubble_flush", 1'b1);
      step();
      rd("after_bubble_epc", 5'd14, 32'h0000_3020);

      // unmapped register and field-masked SR write
      mtc0(5'd5, 32'hDEAD_BEEF);
      rd("unmapped", 5'd5, 32'h0);
      mtc0(5'd12, 32'hFFFF_FFFF);
      rd("sr_mask", 5'd12, 32'h0000_FC03);

      // reset during a flush cycle wins
      mtc0(5'd12, 32'h0000_0401);
      hwint = 6'b000001; pcM = 32'h3040; bdM = 1'b1;
      chk_flush("pre_rst_flush", 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0; hwint = '0; pc_validM = 1'b0; bdM = 1'b0;
      rd("rst2_sr", 5'd12, 32'h0);
      rd("rst2_cause", 5'd13, 32'h0);
      rd("rst2_epc", 5'd14, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
